// File: rtl/nibbler_pkg.sv
// Shared types and constants for the Nibbler program loader.
package nibbler_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int NIB_W_DEF  = 4;
    localparam int PROG_DEPTH = 1 << ADDR_W_DEF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HI,
        ST_LO,
        ST_WR,
        ST_FIN
    } ld_state_t;

endpackage

// File: rtl/prog_addr_counter.sv
// Remaining-byte down-counter with saturating load, plus the
// paired program-memory write address counter.
module prog_addr_counter
    import nibbler_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W:0]   length,
    input  logic              step,
    output logic              last_byte,
    output logic [ADDR_W-1:0] addr
);

    localparam logic [ADDR_W:0]   DEPTH    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W:0] remaining;

    assign last_byte = (remaining == REM_ONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            remaining <= '0;
            addr      <= '0;
        end else if (load) begin
            remaining <= (length > DEPTH) ? DEPTH : length;
            addr      <= '0;
        end else if (step) begin
            remaining <= remaining - REM_ONE;
            // hold on the final byte so a full-depth load never wraps
            if (!last_byte)
                addr <= addr + ADDR_ONE;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Nibble-stream program loader: packs nibble pairs into bytes
// and writes them to program memory while holding the CPU.
module prog_loader
    import nibbler_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NIB_W  = NIB_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_W:0]      length,
    input  logic [NIB_W-1:0]     nib_in,
    input  logic                 nib_valid,
    output logic                 nib_ready,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [2*NIB_W-1:0]   D_out,
    output logic                 cpu_hold,
    output logic                 busy,
    output logic                 done
);

    ld_state_t state, state_nx;
    logic      load;
    logic      step;
    logic      last_byte;

    prog_addr_counter #(.ADDR_W(ADDR_W)) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .length    (length),
        .step      (step),
        .last_byte (last_byte),
        .addr      (mem_addr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        load      = 1'b0;
        step      = 1'b0;
        nib_ready = 1'b0;
        mem_we    = 1'b0;
        done      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = (length != '0) ? ST_HI : ST_FIN;
                end
            end
            ST_HI: begin
                nib_ready = 1'b1;
                if (nib_valid)
                    state_nx = ST_LO;
            end
            ST_LO: begin
                nib_ready = 1'b1;
                if (nib_valid)
                    state_nx = ST_WR;
            end
            ST_WR: begin
                mem_we   = 1'b1;
                step     = 1'b1;
                state_nx = last_byte ? ST_FIN : ST_HI;
            end
            ST_FIN: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign busy     = (state != ST_IDLE);
    assign cpu_hold = busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            D_out <= '0;
        end else begin
            if (state == ST_HI && nib_valid)
                D_out[2*NIB_W-1:NIB_W] <= nib_in;
            if (state == ST_LO && nib_valid)
                D_out[NIB_W-1:0] <= nib_in;
        end
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Program-memory loader for the Nibbler processor: the writer at the other end of the instruction-fetch path. It accepts a stream of 4-bit nibbles over a valid/ready handshake and packs each pair into an 8-bit instruction byte, high nibble first (instruction field, then operand field). It writes each byte into program memory at consecutive 12-bit addresses starting at 0x000, and holds the CPU while a load is in progress. It sits between the external programming port and the program ROM/RAM write port.

## Interface
Parameters:
- ADDR_W, 12, program-memory address width (depth 2^ADDR_W).
- NIB_W, 4, nibble width; byte width is 2*NIB_W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begins a load session; sampled only in IDLE.
- length  in  ADDR_W+1  number of bytes to load; latched when start is accepted.
- nib_in  in  NIB_W  nibble data.
- nib_valid  in  1  nib_in is valid.
- nib_ready  out  1  loader accepts a nibble this cycle.
- mem_we  out  1  program-memory write strobe, one cycle per byte.
- mem_addr  out  ADDR_W  write address.
- D_out  out  2*NIB_W  write data byte; {high nibble, low nibble}.
- cpu_hold  out  1  high while a session is active; gates the CPU fetch enable.
- busy  out  1  session active (state != IDLE).
- done  out  1  one-cycle pulse at session end.

## Operation
- States and transitions:
  - IDLE: start=1 → HI if latched length ≠ 0, else FIN.
  - HI: nibble handshake → LO.
  - LO: nibble handshake → WR.
  - WR: write issued; → FIN if this is the last byte, else HI.
  - FIN: → IDLE unconditionally.
- Handshake: a nibble transfers on a rising edge with nib_valid & nib_ready. nib_ready=1 only in HI and LO. It is decoded from the registered state, with no combinational path from nib_valid.
- Byte packing:
  - Nibble accepted in HI → D_out[7:4].
  - Nibble accepted in LO → D_out[3:0].
- Write: mem_we=1 for exactly the WR cycle, with mem_addr and D_out stable during it. mem_addr increments by 1 on leaving WR.
- Address counter: cleared to 0 when a session starts.
- Length handling:
  - length > 2^ADDR_W saturates to 2^ADDR_W.
  - length = 2^ADDR_W writes addresses 0x000..0xFFF; the address never wraps within a session.
- busy = cpu_hold = (state != IDLE). done = (state == FIN).
- Ignored inputs: start outside IDLE is ignored. nib_valid outside HI/LO is ignored; no data is consumed.
- Reset (any time, including mid-session):
  - State goes to IDLE and all outputs go to 0.
  - Any partial byte is discarded and no write is issued.
  - Memory contents already written are untouched.

## Timing
- Reset values: nib_ready 0, mem_we 0, mem_addr 0, D_out 0x00, cpu_hold 0, busy 0, done 0.
- Handshake latency:
  - Start accepted at edge N → busy/cpu_hold/nib_ready high from cycle N+1.
  - Low nibble accepted at edge M → mem_we high in cycle M+1.
- Throughput: at most one byte per 3 cycles with continuous nib_valid.
- Session end: last write cycle W → done high in W+1 → busy/cpu_hold low from W+2.
- length=0: start at edge N → done in N+1 → IDLE in N+2, with no mem_we.

## Structure
- Shared package nibbler_pkg holds:
  - the loader state encoding (IDLE, HI, LO, WR, FIN);
  - ADDR_W/NIB_W defaults;
  - the program-memory depth constant.
- One natural sub-module: prog_addr_counter.
  - Loadable ADDR_W+1-bit down-counter of remaining bytes, with saturation on load.
  - Paired ADDR_W-bit up-counter for mem_addr.
  - Exposes a last_byte flag.
- FSM and nibble packing stay in prog_loader.

## Test plan
- Reset: hold reset low with random inputs; after release all outputs are 0 and nib_ready is 0 until start.
- Basic load: start with length=2; nibbles 0x3, 0xA, 0xC, 0x5 with nib_valid held high.
  - Expect writes (0x000, 0x3A) then (0x001, 0xC5), each mem_we one cycle, 3 cycles apart.
  - Expect done one cycle after the second write; cpu_hold high from start through done.
- Stalled source: same stream with 0–4 idle cycles between nibbles, plus a start pulse mid-session.
  - Expect identical writes, no extra mem_we, and start ignored.
- Zero length: start with length=0 → no mem_we, done exactly one cycle later, busy low after.
- Reset mid-session: length=4; reset after 3 nibbles.
  - Outputs clear immediately and no write for the partial byte.
  - A following session with length=1 and nibbles 0xF, 0x0 writes (0x000, 0xF0).
- Saturation: length=5000 → exactly 4096 writes, last at 0xFFF, then done.
